sobel_filter_scalable: RTL and testbench

Row-parallel 3×3 Sobel edge-magnitude filter for 8-bit grayscale images. Accepts one full image row of SIZE pixels per valid cycle, keeps the two previous rows internally, and produces one output row of SIZE-2 edge magnitudes per accepted row once three rows of a frame are available. It sits between a frame source (memory reader) and an image sink.

---
 rtl/sobel_pkg.sv | 28 ++
 rtl/sobel_filter_scalable_kernel.sv | 38 +++
 rtl/sobel_filter_scalable.sv | 154 +++++++++++++++
 tb/tb_sobel_filter_scalable.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, pixel/gradient types and the arithmetic helpers
// used by the Sobel edge-magnitude filter.
//   PIX_W   - pixel width (8-bit grayscale)
//   SUM_W   - width of a weighted 1-2-1 column/row sum (max 4*255 = 1020)
//   GRAD_W  - signed gradient width (range +/-1020), also |Gx|+|Gy| width
//   MAG_MAX - output saturation ceiling
package sobel_pkg;

   localparam int PIX_W   = 8;
   localparam int SUM_W   = 10;
   localparam int GRAD_W  = 11;
   localparam int MAG_MAX = 255;

   typedef logic [PIX_W-1:0]         pixel_t;
   typedef logic signed [GRAD_W-1:0] grad_t;
   typedef logic [GRAD_W-1:0]        mag_t;

   // |g| always fits in GRAD_W unsigned bits because |g| <= 1020.
   function automatic mag_t abs_grad(input grad_t g);
      return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
   endfunction

   // Clamp an 11-bit magnitude (max 2040) to the 8-bit output range.
   function automatic pixel_t saturate(input mag_t v);
      return (v > mag_t'(MAG_MAX)) ? pixel_t'(MAG_MAX) : v[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/sobel_filter_scalable_kernel.sv
// sobel_kernel_3x3: purely combinational Sobel operator for one output column.
// Ports:
//   top_l/top_c/top_r - window row n-2, columns L, centre, R
//   mid_l/mid_r       - window row n-1, columns L and R (centre has weight 0)
//   bot_l/bot_c/bot_r - window row n,   columns L, centre, R
//   gx, gy            - signed horizontal / vertical gradients
module sobel_kernel_3x3
   import sobel_pkg::*;
(
   input  logic [PIX_W-1:0]  top_l,
   input  logic [PIX_W-1:0]  top_c,
   input  logic [PIX_W-1:0]  top_r,
   input  logic [PIX_W-1:0]  mid_l,
   input  logic [PIX_W-1:0]  mid_r,
   input  logic [PIX_W-1:0]  bot_l,
   input  logic [PIX_W-1:0]  bot_c,
   input  logic [PIX_W-1:0]  bot_r,
   output logic [GRAD_W-1:0] gx,
   output logic [GRAD_W-1:0] gy
);

   logic [SUM_W-1:0] sum_left;
   logic [SUM_W-1:0] sum_right;
   logic [SUM_W-1:0] sum_top;
   logic [SUM_W-1:0] sum_bot;

   // 1-2-1 weighted sums; the x2 term is a left shift by concatenation.
   assign sum_left  = SUM_W'(top_l) + {1'b0, mid_l, 1'b0} + SUM_W'(bot_l);
   assign sum_right = SUM_W'(top_r) + {1'b0, mid_r, 1'b0} + SUM_W'(bot_r);
   assign sum_top   = SUM_W'(top_l) + {1'b0, top_c, 1'b0} + SUM_W'(top_r);
   assign sum_bot   = SUM_W'(bot_l) + {1'b0, bot_c, 1'b0} + SUM_W'(bot_r);

   // Zero-extend by one bit before subtracting so the result is a proper
   // signed value in +/-1020.
   assign gx = {1'b0, sum_right} - {1'b0, sum_left};
   assign gy = {1'b0, sum_bot}   - {1'b0, sum_top};

endmodule

// File: rtl/sobel_filter_scalable.sv
// sobel_filter_scalable: row-parallel 3x3 Sobel edge-magnitude filter.
// One full image row is accepted per valid cycle; two previous rows are kept
// in a line buffer and one output row of SIZE-2 magnitudes is produced per
// accepted row once three rows of the current frame are available.
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   in_valid   - arr_in carries a row this cycle (no backpressure)
//   sof        - start of frame, only meaningful together with in_valid
//   arr_in     - input row, element c = column c
//   out_valid  - single-cycle pulse: arr_out holds a new row
//   arr_out    - output row, element c = magnitude centred on column c+1;
//                holds its value until the next out_valid pulse
// Handshake: a row is transferred on every rising edge where in_valid is 1;
// the block never stalls. out_valid is a one-cycle strobe with no ready.
// Pipeline (edge k samples the row):
//   k   : input register (in_row, in_v, in_sof)
//   k+1 : S0 line-buffer shift, row counter update, window capture
//   k+2 : S1 Gx/Gy registered
//   k+3 : S2 |Gx|+|Gy| saturated into arr_out, out_valid pulses
module sobel_filter_scalable
   import sobel_pkg::*;
#(
   parameter int SIZE = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       sof,
   input  logic [7:0] arr_in  [SIZE-1:0],
   output logic       out_valid,
   output logic [7:0] arr_out [SIZE-3:0]
);

   localparam int OW = SIZE - 2;

   logic [7:0]        in_row  [SIZE-1:0];
   logic              in_v;
   logic              in_sof;

   logic [7:0]        row_m1  [SIZE-1:0];
   logic [7:0]        row_m2  [SIZE-1:0];
   // Saturating count of rows accepted in this frame: 0, 1, 2 (= two or more).
   logic [1:0]        row_cnt;

   logic [7:0]        win_top [SIZE-1:0];
   logic [7:0]        win_mid [SIZE-1:0];
   logic [7:0]        win_bot [SIZE-1:0];
   logic              s0_v;

   logic [GRAD_W-1:0] gx_w    [OW-1:0];
   logic [GRAD_W-1:0] gy_w    [OW-1:0];
   grad_t             gx_r    [OW-1:0];
   grad_t             gy_r    [OW-1:0];
   logic              s1_v;

   logic              win_en;

   // A window exists only if two earlier rows of the same frame are buffered.
   // A sof row restarts the frame, so it never completes a window itself.
   assign win_en = in_v && !in_sof && (row_cnt == 2'd2);

   // Input register, line buffer and row counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_v    <= 1'b0;
         in_sof  <= 1'b0;
         row_cnt <= 2'd0;
         for (int i = 0; i < SIZE; i++) begin
            in_row[i] <= '0;
            row_m1[i] <= '0;
            row_m2[i] <= '0;
         end
      end else begin
         in_v   <= in_valid;
         in_sof <= in_valid && sof;
         if (in_valid) begin
            for (int i = 0; i < SIZE; i++) in_row[i] <= arr_in[i];
         end
         if (in_v) begin
            for (int i = 0; i < SIZE; i++) begin
               row_m2[i] <= row_m1[i];
               row_m1[i] <= in_row[i];
            end
            if (in_sof)
               row_cnt <= 2'd1;
            else if (row_cnt != 2'd2)
               row_cnt <= row_cnt + 2'd1;
         end
      end
   end

   // S0 window capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_v <= 1'b0;
         for (int i = 0; i < SIZE; i++) begin
            win_top[i] <= '0;
            win_mid[i] <= '0;
            win_bot[i] <= '0;
         end
      end else begin
         s0_v <= win_en;
         if (win_en) begin
            for (int i = 0; i < SIZE; i++) begin
               win_top[i] <= row_m2[i];
               win_mid[i] <= row_m1[i];
               win_bot[i] <= in_row[i];
            end
         end
      end
   end

   for (genvar c = 0; c < OW; c++) begin : g_col
      sobel_kernel_3x3 u_kernel (
         .top_l (win_top[c]),
         .top_c (win_top[c+1]),
         .top_r (win_top[c+2]),
         .mid_l (win_mid[c]),
         .mid_r (win_mid[c+2]),
         .bot_l (win_bot[c]),
         .bot_c (win_bot[c+1]),
         .bot_r (win_bot[c+2]),
         .gx    (gx_w[c]),
         .gy    (gy_w[c])
      );
   end

   // S1 gradient registers and S2 magnitude/saturation into arr_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v      <= 1'b0;
         out_valid <= 1'b0;
         for (int c = 0; c < OW; c++) begin
            gx_r[c]    <= '0;
            gy_r[c]    <= '0;
            arr_out[c] <= '0;
         end
      end else begin
         s1_v      <= s0_v;
         out_valid <= s1_v;
         if (s0_v) begin
            for (int c = 0; c < OW; c++) begin
               gx_r[c] <= grad_t'(gx_w[c]);
               gy_r[c] <= grad_t'(gy_w[c]);
            end
         end
         if (s1_v) begin
            for (int c = 0; c < OW; c++)
               arr_out[c] <= saturate(abs_grad(gx_r[c]) + abs_grad(gy_r[c]));
         end
      end
   end

endmodule

// File: tb/tb_sobel_filter_scalable.sv
// Bench for sobel_filter_scalable at SIZE = 8. A frame-level reference model
// keeps the rows of the current frame and computes each output row straight
// from the Sobel formulas; a negedge collector records every out_valid row
// with its cycle number, and each test compares the collected rows against
// the model (values and 3-edge latency) plus directed constants.
module tb_sobel_filter_scalable;

   localparam int SIZE = 8;
   localparam int OW   = SIZE - 2;
   localparam int W    = 8 * OW;

   typedef logic [7:0] row_t [SIZE-1:0];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       sof = 1'b0;
   logic [7:0] arr_in  [SIZE-1:0];
   logic       out_valid;
   logic [7:0] arr_out [SIZE-3:0];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];
   int           exp_cyc_q[$];
   int           obs_cyc_q[$];
   row_t         hist[$];

   sobel_filter_scalable #(.SIZE(SIZE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .sof       (sof),
      .arr_in    (arr_in),
      .out_valid (out_valid),
      .arr_out   (arr_out)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [W-1:0] pack_out();
      logic [W-1:0] p;
      for (int c = 0; c < OW; c++) p[c*8 +: 8] = arr_out[c];
      return p;
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         obs_q.push_back(pack_out());
         obs_cyc_q.push_back(cyc);
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] ref_row(input row_t t, input row_t m, input row_t b);
      logic [W-1:0] r;
      int gx, gy, mag;
      r = '0;
      for (int c = 0; c < OW; c++) begin
         gx = (int'(t[c+2]) + 2*int'(m[c+2]) + int'(b[c+2]))
            - (int'(t[c])   + 2*int'(m[c])   + int'(b[c]));
         gy = (int'(b[c]) + 2*int'(b[c+1]) + int'(b[c+2]))
            - (int'(t[c]) + 2*int'(t[c+1]) + int'(t[c+2]));
         mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
         if (mag > 255) mag = 255;
         r[c*8 +: 8] = mag[7:0];
      end
      return r;
   endfunction

   // Row driven at a negedge is sampled on the next edge (cyc+1) and shows up
   // on the collector three edges later, i.e. at cycle cyc+4.
   function automatic void model_accept(input row_t r, input logic s);
      int n;
      if (s) hist.delete();
      hist.push_back(r);
      if (hist.size() > 3) void'(hist.pop_front());
      n = hist.size();
      if (n == 3) begin
         exp_q.push_back(ref_row(hist[0], hist[1], hist[2]));
         exp_cyc_q.push_back(cyc + 4);
      end
   endfunction

   function automatic void clear_queues();
      exp_q.delete(); obs_q.delete(); exp_cyc_q.delete(); obs_cyc_q.delete();
   endfunction

   // ---------------- drivers ----------------
   task automatic send_row(input row_t r, input logic s);
      @(negedge clk);
      in_valid = 1'b1;
      sof      = s;
      for (int i = 0; i < SIZE; i++) arr_in[i] = r[i];
      model_accept(r, s);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         sof      = 1'($urandom_range(0, 1));
         for (int i = 0; i < SIZE; i++) arr_in[i] = 8'($urandom_range(0, 255));
      end
   endtask

   function automatic row_t rand_row();
      row_t r;
      for (int i = 0; i < SIZE; i++) r[i] = 8'($urandom_range(0, 255));
      return r;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      #3;
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      n_tests++;
      if (pack_out() !== '0) begin
         n_fail++; $display("FAIL reset_arr_out: got %h expected 0", pack_out());
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_uniform();
      row_t r;
      for (int c = 0; c < SIZE; c++) r[c] = 8'd80;
      for (int y = 0; y < 8; y++) send_row(r, y == 0);
      idle(8);
      n_tests++;
      if (obs_q.size() != 6) begin
         n_fail++; $display("FAIL uniform_pulses: got %0d expected 6", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_cyc_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== '0) begin
            n_fail++; $display("FAIL uniform_row%0d: got %h expected 0", i, obs_q[i]);
         end
         n_tests++;
         if (obs_cyc_q[i] !== exp_cyc_q[i]) begin
            n_fail++; $display("FAIL uniform_latency%0d: got cycle %0d expected %0d", i, obs_cyc_q[i], exp_cyc_q[i]);
         end
      end
      clear_queues();
   endtask

   task automatic test_vertical_step();
      row_t r;
      logic [7:0] e;
      for (int c = 0; c < SIZE; c++) r[c] = (c < 4) ? 8'd0 : 8'd50;
      for (int y = 0; y < 8; y++) send_row(r, y == 0);
      idle(8);
      n_tests++;
      if (obs_q.size() != 6) begin
         n_fail++; $display("FAIL vstep_pulses: got %0d expected 6", obs_q.size());
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         for (int c = 0; c < OW; c++) begin
            e = (c == 2 || c == 3) ? 8'd200 : 8'd0;
            n_tests++;
            if (obs_q[i][c*8 +: 8] !== e) begin
               n_fail++; $display("FAIL vstep_r%0d_c%0d: got %0d expected %0d", i, c, obs_q[i][c*8 +: 8], e);
            end
         end
      end
      clear_queues();
   endtask

   task automatic test_horizontal_step();
      row_t r;
      logic [W-1:0] e;
      for (int y = 0; y < 8; y++) begin
         for (int c = 0; c < SIZE; c++) r[c] = (y < 4) ? 8'd0 : 8'd100;
         send_row(r, y == 0);
      end
      idle(8);
      n_tests++;
      if (obs_q.size() != 6) begin
         n_fail++; $display("FAIL hstep_pulses: got %0d expected 6", obs_q.size());
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         e = (i == 2 || i == 3) ? {OW{8'd255}} : '0;
         n_tests++;
         if (obs_q[i] !== e) begin
            n_fail++; $display("FAIL hstep_row%0d: got %h expected %h", i, obs_q[i], e);
         end
      end
      clear_queues();
   endtask

   task automatic test_single_pixel();
      row_t r;
      for (int y = 0; y < 8; y++) begin
         for (int c = 0; c < SIZE; c++) r[c] = (y == 3 && c == 3) ? 8'd255 : 8'd0;
         send_row(r, y == 0);
      end
      idle(8);
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL pixel_pulses: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      if (obs_q.size() >= 3) begin
         n_tests++;
         if (obs_q[1][1*8 +: 8] !== 8'd255) begin
            n_fail++; $display("FAIL pixel_corner: got %0d expected 255", obs_q[1][1*8 +: 8]);
         end
         n_tests++;
         if (obs_q[2][1*8 +: 8] !== 8'd255) begin
            n_fail++; $display("FAIL pixel_side: got %0d expected 255", obs_q[2][1*8 +: 8]);
         end
         n_tests++;
         if (obs_q[2][2*8 +: 8] !== 8'd0) begin
            n_fail++; $display("FAIL pixel_centre: got %0d expected 0", obs_q[2][2*8 +: 8]);
         end
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL pixel_row%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
         n_tests++;
         if (obs_cyc_q[i] !== exp_cyc_q[i]) begin
            n_fail++; $display("FAIL pixel_latency%0d: got cycle %0d expected %0d", i, obs_cyc_q[i], exp_cyc_q[i]);
         end
      end
      clear_queues();
   endtask

   task automatic test_gaps_sof();
      int n1, n2;
      n1 = $urandom_range(5, 10);
      n2 = $urandom_range(3, 8);
      for (int y = 0; y < n1 + n2; y++) begin
         send_row(rand_row(), (y == 0) || (y == n1));
         idle($urandom_range(0, 3));
      end
      idle(8);
      n_tests++;
      if (obs_q.size() != (n1 - 2) + (n2 - 2)) begin
         n_fail++; $display("FAIL gaps_pulses: got %0d expected %0d", obs_q.size(), (n1 - 2) + (n2 - 2));
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL gaps_row%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
         n_tests++;
         if (obs_cyc_q[i] !== exp_cyc_q[i]) begin
            n_fail++; $display("FAIL gaps_latency%0d: got cycle %0d expected %0d", i, obs_cyc_q[i], exp_cyc_q[i]);
         end
      end
      clear_queues();
   endtask

   task automatic test_back_to_back();
      int h, total;
      total = 0;
      for (int f = 0; f < 3; f++) begin
         h = $urandom_range(3, 6);
         total += h - 2;
         for (int y = 0; y < h; y++) send_row(rand_row(), y == 0);
      end
      idle(8);
      n_tests++;
      if (obs_q.size() != total) begin
         n_fail++; $display("FAIL b2b_pulses: got %0d expected %0d", obs_q.size(), total);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL b2b_row%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
         n_tests++;
         if (obs_cyc_q[i] !== exp_cyc_q[i]) begin
            n_fail++; $display("FAIL b2b_latency%0d: got cycle %0d expected %0d", i, obs_cyc_q[i], exp_cyc_q[i]);
         end
      end
      clear_queues();
   endtask

   task automatic test_async_reset();
      row_t z, h;
      for (int c = 0; c < SIZE; c++) begin
         z[c] = 8'd0;
         h[c] = 8'd100;
      end
      // Rows 0,0,100,100: first output (all 255) appears three idles after
      // the last row, while the second output is still in flight.
      send_row(z, 1'b1);
      send_row(z, 1'b0);
      send_row(h, 1'b0);
      send_row(h, 1'b0);
      idle(3);
      #2;
      n_tests++;
      if (out_valid !== 1'b1 || pack_out() !== {OW{8'd255}}) begin
         n_fail++; $display("FAIL pre_reset_out: got valid %b data %h expected 1 / all ff", out_valid, pack_out());
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL async_reset_valid: got %b expected 0", out_valid);
      end
      n_tests++;
      if (pack_out() !== '0) begin
         n_fail++; $display("FAIL async_reset_data: got %h expected 0", pack_out());
      end
      clear_queues();
      hist.delete();
      idle(2);
      rst_n = 1'b1;
      idle(1);
      // No sof: the first row after reset still starts a new frame.
      for (int y = 0; y < 3; y++) send_row(rand_row(), 1'b0);
      idle(8);
      n_tests++;
      if (obs_q.size() != 1) begin
         n_fail++; $display("FAIL post_reset_pulses: got %0d expected 1", obs_q.size());
      end
      if (obs_q.size() >= 1 && exp_q.size() >= 1) begin
         n_tests++;
         if (obs_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL post_reset_row: got %h expected %h", obs_q[0], exp_q[0]);
         end
         n_tests++;
         if (obs_cyc_q[0] !== exp_cyc_q[0]) begin
            n_fail++; $display("FAIL post_reset_latency: got cycle %0d expected %0d", obs_cyc_q[0], exp_cyc_q[0]);
         end
      end
      clear_queues();
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      for (int i = 0; i < SIZE; i++) arr_in[i] = 8'd0;
      test_reset();
      test_uniform();
      test_vertical_step();
      test_horizontal_step();
      test_single_pixel();
      test_gaps_sof();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
